// File: rtl/pong_pkg.sv
// Shared state encodings, screen defaults and ball record for the pong game path.
package pong_pkg;

  localparam logic [1:0] QI      = 2'b00;
  localparam logic [1:0] QGAME_1 = 2'b01;
  localparam logic [1:0] QGAME_2 = 2'b10;
  localparam logic [1:0] QDONE   = 2'b11;

  localparam int SCREEN_W_DEF = 640;
  localparam int SCREEN_H_DEF = 480;

  localparam logic [9:0] CENTRE_X = 10'd316;
  localparam logic [8:0] CENTRE_Y = 9'd236;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       dir_x;
    logic       dir_y;
  } ball_t;

  localparam ball_t BALL_RST = '{x: CENTRE_X, y: CENTRE_Y, dir_x: DIR_RIGHT, dir_y: DIR_DOWN};

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s < lim) ? s + 4'd1 : s;
  endfunction

endpackage

// File: rtl/pong_ball_step.sv
// One frame of ball motion: wall bounce on Y, paddle hit or miss on X.
module pong_ball_step
  import pong_pkg::*;
#(
  parameter int SCREEN_H  = SCREEN_H_DEF,
  parameter int BALL_SIZE = 8,
  parameter int PADDLE_W  = 10,
  parameter int PADDLE_H  = 50,
  parameter int P1_X      = 0,
  parameter int P2_X      = 630,
  parameter int SPEED     = 2
) (
  input  ball_t      ball_i,
  input  logic [8:0] p1_y_i,
  input  logic [8:0] p2_y_i,
  output ball_t      ball_o,
  output logic       p1_point_o,
  output logic       p2_point_o
);

  localparam logic [10:0] L_LIMIT = 11'(P1_X + PADDLE_W + SPEED);
  localparam logic [10:0] R_LIMIT = 11'(P2_X);
  localparam logic [9:0]  Y_BOT   = 10'(SCREEN_H);

  // Widened copies so edge compares cannot wrap.
  logic [10:0] x11;
  logic [9:0]  y10, p1y10, p2y10;
  logic        p1_ovl, p2_ovl;

  assign x11   = {1'b0, ball_i.x};
  assign y10   = {1'b0, ball_i.y};
  assign p1y10 = {1'b0, p1_y_i};
  assign p2y10 = {1'b0, p2_y_i};

  assign p1_ovl = (y10 + 10'(BALL_SIZE) > p1y10) && (y10 < p1y10 + 10'(PADDLE_H));
  assign p2_ovl = (y10 + 10'(BALL_SIZE) > p2y10) && (y10 < p2y10 + 10'(PADDLE_H));

  always_comb begin
    ball_o     = ball_i;
    p1_point_o = 1'b0;
    p2_point_o = 1'b0;

    if (ball_i.dir_y == DIR_UP) begin
      if (y10 < 10'(SPEED)) begin
        ball_o.y     = '0;
        ball_o.dir_y = DIR_DOWN;
      end else begin
        ball_o.y = 9'(y10 - 10'(SPEED));
      end
    end else begin
      if (y10 + 10'(BALL_SIZE) + 10'(SPEED) > Y_BOT) begin
        ball_o.y     = 9'(SCREEN_H - BALL_SIZE);
        ball_o.dir_y = DIR_UP;
      end else begin
        ball_o.y = 9'(y10 + 10'(SPEED));
      end
    end

    if (ball_i.dir_x == DIR_LEFT) begin
      if (x11 < L_LIMIT) begin
        if (p1_ovl) begin
          ball_o.x     = 10'(P1_X + PADDLE_W);
          ball_o.dir_x = DIR_RIGHT;
        end else begin
          p2_point_o = 1'b1;
        end
      end else begin
        ball_o.x = 10'(x11 - 11'(SPEED));
      end
    end else begin
      if (x11 + 11'(BALL_SIZE) + 11'(SPEED) > R_LIMIT) begin
        if (p2_ovl) begin
          ball_o.x     = 10'(P2_X - BALL_SIZE);
          ball_o.dir_x = DIR_LEFT;
        end else begin
          p1_point_o = 1'b1;
        end
      end else begin
        ball_o.x = 10'(x11 + 11'(SPEED));
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: idle / rally / serve pause / done, scores and ball state.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_W     = SCREEN_W_DEF,
  parameter int SCREEN_H     = SCREEN_H_DEF,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 50,
  parameter int P1_X         = 0,
  parameter int P2_X         = 630,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 10
) (
  input  logic       board_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic [8:0] p1_y,
  input  logic [8:0] p2_y,
  output logic [9:0] ball_x,
  output logic [8:0] ball_y,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] state,
  output logic       winner
);

  localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN4       = 4'(WIN_SCORE);
  // A right paddle placed past the screen edge still bounces at the edge.
  localparam int RIGHT_EDGE = (P2_X < SCREEN_W) ? P2_X : SCREEN_W;

  logic [1:0]       state_q, state_d;
  ball_t            ball_q, ball_d, step_ball;
  logic [3:0]       p1_sc_q, p1_sc_d, p2_sc_q, p2_sc_d;
  logic             winner_q, winner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;
  logic             p1_pt, p2_pt;

  pong_ball_step #(
    .SCREEN_H (SCREEN_H),
    .BALL_SIZE(BALL_SIZE),
    .PADDLE_W (PADDLE_W),
    .PADDLE_H (PADDLE_H),
    .P1_X     (P1_X),
    .P2_X     (RIGHT_EDGE),
    .SPEED    (SPEED)
  ) u_step (
    .ball_i    (ball_q),
    .p1_y_i    (p1_y),
    .p2_y_i    (p2_y),
    .ball_o    (step_ball),
    .p1_point_o(p1_pt),
    .p2_point_o(p2_pt)
  );

  always_comb begin
    state_d  = state_q;
    ball_d   = ball_q;
    p1_sc_d  = p1_sc_q;
    p2_sc_d  = p2_sc_q;
    winner_d = winner_q;
    cnt_d    = cnt_q;

    if (!start && (state_q == QGAME_1 || state_q == QGAME_2)) begin
      // Abort wins over any pending tick; directions are left as they were.
      state_d  = QI;
      p1_sc_d  = '0;
      p2_sc_d  = '0;
      ball_d.x = CENTRE_X;
      ball_d.y = CENTRE_Y;
    end else begin
      case (state_q)
        QI: begin
          p1_sc_d  = '0;
          p2_sc_d  = '0;
          ball_d.x = CENTRE_X;
          ball_d.y = CENTRE_Y;
          if (start) begin
            state_d      = QGAME_2;
            cnt_d        = SERVE_LOAD;
            ball_d.dir_x = DIR_RIGHT;
          end
        end
        QGAME_2: begin
          ball_d.x = CENTRE_X;
          ball_d.y = CENTRE_Y;
          if (tick_q) begin
            if (cnt_q <= CNT_ONE) begin
              cnt_d   = '0;
              state_d = QGAME_1;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
        end
        QGAME_1: begin
          if (tick_q) begin
            ball_d = step_ball;
            if (p1_pt || p2_pt) begin
              ball_d.x = CENTRE_X;
              ball_d.y = CENTRE_Y;
              if (p1_pt) begin
                p1_sc_d      = sat_inc(p1_sc_q, WIN4);
                ball_d.dir_x = DIR_RIGHT;
              end else begin
                p2_sc_d      = sat_inc(p2_sc_q, WIN4);
                ball_d.dir_x = DIR_LEFT;
              end
              if ((p1_pt ? p1_sc_d : p2_sc_d) == WIN4) begin
                state_d  = QDONE;
                winner_d = p2_pt;
              end else begin
                state_d = QGAME_2;
                cnt_d   = SERVE_LOAD;
              end
            end
          end
        end
        default: begin
          if (!start) begin
            state_d  = QI;
            p1_sc_d  = '0;
            p2_sc_d  = '0;
            ball_d.x = CENTRE_X;
            ball_d.y = CENTRE_Y;
          end
        end
      endcase
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q  <= QI;
      ball_q   <= BALL_RST;
      p1_sc_q  <= '0;
      p2_sc_q  <= '0;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ball_q   <= ball_d;
      p1_sc_q  <= p1_sc_d;
      p2_sc_q  <= p2_sc_d;
      winner_q <= winner_d;
      cnt_q    <= cnt_d;
      tick_q   <= frame_tick;
    end
  end

  assign ball_x   = ball_q.x;
  assign ball_y   = ball_q.y;
  assign p1_score = p1_sc_q;
  assign p2_score = p2_sc_q;
  assign state    = state_q;
  assign winner   = winner_q;

endmodule
